// File: rtl/data_memory_ctrl.sv
// Handshaked single-port word RAM with byte lanes, wait states and a sticky range-fault record.
// Optional per-word even parity is enabled by defining DMEM_PARITY_EN.
module data_memory_ctrl #(
    parameter int DATA_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int DATA_SIZE       = 1024,
    parameter int WAIT_STATES     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req,
    input  logic                       write,
    input  logic [DATA_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic [DATA_WIDTH/8-1:0]    byte_en,
    output logic                       ready,
    output logic                       resp_valid,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       exception,
    output logic                       exc_flag,
    output logic [DATA_ADDR_WIDTH-1:0] exc_addr,
    input  logic                       exc_clr
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [DATA_ADDR_WIDTH:0] SIZE_LIMIT = (DATA_ADDR_WIDTH + 1)'(DATA_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                     state_reg, state_next;
    logic [3:0]                 cnt_reg;
    logic                       write_reg;
    logic [DATA_ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0]      data_reg;
    logic [LANES-1:0]           be_reg;
    logic                       resp_valid_reg, exception_reg, rd_sel_reg, exc_flag_reg;
    logic [DATA_ADDR_WIDTH-1:0] exc_addr_reg;
    logic [DATA_WIDTH-1:0]      rd_data_reg;
    logic [DATA_WIDTH-1:0]      mem [DATA_SIZE];

    logic                       accept, enter_resp, in_range, mem_we, fault, parity_err;
    logic                       cur_write;
    logic [DATA_ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0]      cur_data;
    logic [LANES-1:0]           cur_be;
    logic [IDX_W-1:0]           idx;

    // With zero wait states RESP is entered on the accepting edge, so the live inputs are used.
    always_comb begin
        cur_write = write_reg;
        cur_addr  = addr_reg;
        cur_data  = data_reg;
        cur_be    = be_reg;
        if (state_reg == S_IDLE) begin
            cur_write = write;
            cur_addr  = addr;
            cur_data  = data_in;
            cur_be    = byte_en;
        end
    end

    assign idx      = cur_addr[IDX_W-1:0];
    assign in_range = {1'b0, cur_addr} < SIZE_LIMIT;
    assign mem_we   = enter_resp && cur_write && in_range;
    assign fault    = enter_resp && (!in_range || parity_err);

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        enter_resp = 1'b0;
        ready      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_next = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 4'd0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            data_reg       <= '0;
            be_reg         <= '0;
            resp_valid_reg <= 1'b0;
            exception_reg  <= 1'b0;
            rd_sel_reg     <= 1'b0;
            exc_flag_reg   <= 1'b0;
            exc_addr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_WAIT && cnt_reg != WAIT_LAST) cnt_reg <= cnt_reg + 4'd1;
            else cnt_reg <= 4'd0;
            if (accept) begin
                write_reg <= write;
                addr_reg  <= addr;
                data_reg  <= data_in;
                be_reg    <= byte_en;
            end
            resp_valid_reg <= enter_resp;
            exception_reg  <= fault;
            rd_sel_reg     <= enter_resp && !cur_write && in_range;
            // A fault arriving together with a clear takes precedence and is recorded.
            if (fault && (!exc_flag_reg || exc_clr)) begin
                exc_flag_reg <= 1'b1;
                exc_addr_reg <= cur_addr;
            end else if (exc_clr) begin
                exc_flag_reg <= 1'b0;
                exc_addr_reg <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_we && cur_be[i]) mem[idx][8*i +: 8] <= cur_data[8*i +: 8];
        end
        rd_data_reg <= mem[idx];
    end

`ifdef DMEM_PARITY_EN
    logic                  par_mem [DATA_SIZE];
    logic [DATA_SIZE-1:0]  written_reg;
    logic [DATA_WIDTH-1:0] merged;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_merge
            assign merged[8*gi +: 8] = cur_be[gi] ? cur_data[8*gi +: 8] : mem[idx][8*gi +: 8];
        end
    endgenerate

    assign parity_err = !cur_write && in_range && written_reg[idx] && (^{par_mem[idx], mem[idx]});

    always_ff @(posedge clk) begin
        if (mem_we) par_mem[idx] <= ^merged;
    end

    // Words never written carry no valid parity and are never flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) written_reg <= '0;
        else if (mem_we) written_reg[idx] <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign resp_valid = resp_valid_reg;
    assign exception  = exception_reg;
    assign data_out   = (resp_valid_reg && rd_sel_reg) ? rd_data_reg : '0;
    assign exc_flag   = exc_flag_reg;
    assign exc_addr   = exc_addr_reg;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomised self-checking bench for data_memory_ctrl against an array-based reference model.
// Define DMEM_PARITY_EN to also exercise the parity check.
module tb_data_memory_ctrl;
    localparam int WS   = 1;
    localparam int SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst_n, req, write, exc_clr;
    logic [15:0] addr, data_in;
    logic [1:0]  byte_en;
    logic        ready, resp_valid, exception, exc_flag;
    logic [15:0] data_out, exc_addr;

    int total = 0;
    int bad   = 0;

    data_memory_ctrl #(
        .DATA_ADDR_WIDTH(16), .DATA_WIDTH(16), .DATA_SIZE(SIZE), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .write(write), .addr(addr),
        .data_in(data_in), .byte_en(byte_en), .ready(ready), .resp_valid(resp_valid),
        .data_out(data_out), .exception(exception), .exc_flag(exc_flag),
        .exc_addr(exc_addr), .exc_clr(exc_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old_w;
        if (be[0]) r[7:0]  = new_w[7:0];
        if (be[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    // Issue one request starting at a negedge; returns at the negedge of the response cycle.
    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] be, output logic [15:0] q, output logic ex,
                       output int lat);
        int n;
        req = 1'b1; write = w; addr = a; data_in = d; byte_en = be;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req = 1'b0; addr = 16'($urandom); data_in = 16'($urandom); byte_en = 2'($urandom);
        lat = -1; q = 16'hxxxx; ex = 1'bx;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c; q = data_out; ex = exception;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; write = 1'b0; addr = '0; data_in = '0; byte_en = '0;
        exc_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({ready, resp_valid, exception, exc_flag} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=1000", {ready, resp_valid, exception, exc_flag});
        end
        total++;
        if (data_out !== 16'h0 || exc_addr !== 16'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h want=0000/0000", data_out, exc_addr);
        end
        $display("reset: ready=%b data_out=%h exc_addr=%h", ready, data_out, exc_addr);
    endtask

    task automatic test_write_read;
        logic [15:0] q; logic ex; int lat;
        txn(1'b1, 16'd5, 16'hBEEF, 2'b11, q, ex, lat);
        $display("write a=5 d=BEEF lat=%0d q=%h ex=%b", lat, q, ex);
        total++;
        if (lat !== WS + 1 || q !== 16'h0 || ex !== 1'b0) begin
            bad++;
            $display("FAIL wr_resp got lat=%0d q=%h ex=%b want lat=%0d q=0000 ex=0", lat, q, ex, WS + 1);
        end
        txn(1'b0, 16'd5, 16'h0, 2'b00, q, ex, lat);
        $display("read a=5 lat=%0d q=%h ex=%b", lat, q, ex);
        total++;
        if (lat !== WS + 1 || q !== 16'hBEEF || ex !== 1'b0) begin
            bad++;
            $display("FAIL rd_resp got lat=%0d q=%h ex=%b want lat=%0d q=BEEF ex=0", lat, q, ex, WS + 1);
        end
    endtask

    task automatic test_byte_lanes;
        logic [15:0] q; logic ex; int lat;
        logic [1:0]  be_tab [3];
        logic [15:0] want_tab [3];
        be_tab = '{2'b01, 2'b00, 2'b10};
        want_tab = '{16'h12CD, 16'h12CD, 16'h55CD};
        txn(1'b1, 16'd7, 16'h1234, 2'b11, q, ex, lat);
        for (int i = 0; i < 3; i++) begin
            txn(1'b1, 16'd7, (i == 2) ? 16'h5566 : 16'hABCD, be_tab[i], q, ex, lat);
            total++;
            if (lat !== WS + 1 || ex !== 1'b0) begin
                bad++;
                $display("FAIL lane_wr%0d got lat=%0d ex=%b want lat=%0d ex=0", i, lat, ex, WS + 1);
            end
            txn(1'b0, 16'd7, 16'h0, 2'b11, q, ex, lat);
            $display("lanes be=%b read a=7 q=%h", be_tab[i], q);
            total++;
            if (q !== want_tab[i]) begin
                bad++;
                $display("FAIL lane_rd%0d got=%h want=%h", i, q, want_tab[i]);
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [15:0] q; logic ex; int lat;
        txn(1'b1, 16'd0, 16'h1111, 2'b11, q, ex, lat);
        txn(1'b1, 16'd1023, 16'h2222, 2'b11, q, ex, lat);
        txn(1'b0, 16'd1023, 16'h0, 2'b11, q, ex, lat);
        total++;
        if (q !== 16'h2222 || ex !== 1'b0 || exc_flag !== 1'b0) begin
            bad++;
            $display("FAIL edge_1023 got q=%h ex=%b flag=%b want 2222/0/0", q, ex, exc_flag);
        end
        txn(1'b1, 16'd1024, 16'hFFFF, 2'b11, q, ex, lat);
        $display("oor write a=1024 q=%h ex=%b flag=%b exc_addr=%0d", q, ex, exc_flag, exc_addr);
        total++;
        if (q !== 16'h0 || ex !== 1'b1 || exc_flag !== 1'b1 || exc_addr !== 16'd1024) begin
            bad++;
            $display("FAIL oor_wr got q=%h ex=%b flag=%b ea=%0d want 0000/1/1/1024",
                     q, ex, exc_flag, exc_addr);
        end
        txn(1'b0, 16'd0, 16'h0, 2'b11, q, ex, lat);
        total++;
        if (q !== 16'h1111 || ex !== 1'b0) begin
            bad++;
            $display("FAIL oor_no_alias got q=%h ex=%b want 1111/0", q, ex);
        end
        txn(1'b0, 16'd2000, 16'h0, 2'b11, q, ex, lat);
        $display("oor read a=2000 q=%h ex=%b exc_addr=%0d", q, ex, exc_addr);
        total++;
        if (q !== 16'h0 || ex !== 1'b1 || exc_addr !== 16'd1024) begin
            bad++;
            $display("FAIL oor_sticky got q=%h ex=%b ea=%0d want 0000/1/1024", q, ex, exc_addr);
        end
        exc_clr = 1'b1;
        @(negedge clk);
        exc_clr = 1'b0;
        $display("exc_clr flag=%b exc_addr=%0d", exc_flag, exc_addr);
        total++;
        if (exc_flag !== 1'b0 || exc_addr !== 16'd0) begin
            bad++;
            $display("FAIL exc_clr got flag=%b ea=%0d want 0/0", exc_flag, exc_addr);
        end
    endtask

    task automatic test_clr_vs_fault;
        logic [15:0] q; logic ex; int lat;
        txn(1'b0, 16'd1500, 16'h0, 2'b11, q, ex, lat);
        exc_clr = 1'b1;
        txn(1'b0, 16'd3000, 16'h0, 2'b11, q, ex, lat);
        exc_clr = 1'b0;
        $display("clr+fault a=3000 ex=%b flag=%b exc_addr=%0d", ex, exc_flag, exc_addr);
        total++;
        if (ex !== 1'b1 || exc_flag !== 1'b1 || exc_addr !== 16'd3000) begin
            bad++;
            $display("FAIL clr_vs_fault got ex=%b flag=%b ea=%0d want 1/1/3000", ex, exc_flag, exc_addr);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] q; logic ex; int lat;
        int acc, resp, low, cyc;
        acc = 0; resp = 0; low = 0; cyc = 0;
        req = 1'b1; write = 1'b1; addr = 16'd40; data_in = 16'hC000; byte_en = 2'b11;
        while (cyc < 200 && (acc < 4 || resp < 4)) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) resp++;
            if (!ready) begin
                low++;
            end else begin
                if (low > 0) begin
                    total++;
                    if (low != WS + 1) begin
                        bad++;
                        $display("FAIL b2b_ready_low got=%0d want=%0d", low, WS + 1);
                    end
                    low = 0;
                end
                if (req) begin
                    @(posedge clk);
                    #1;
                    acc++;
                    if (acc < 4) begin
                        addr = 16'(40 + acc);
                        data_in = 16'hC000 + 16'(acc);
                    end else begin
                        req = 1'b0;
                    end
                end
            end
        end
        $display("b2b accepted=%0d responses=%0d cycles=%0d", acc, resp, cyc);
        total++;
        if (acc != 4 || resp != 4) begin
            bad++;
            $display("FAIL b2b_count got acc=%0d resp=%0d want 4/4", acc, resp);
        end
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, 16'(40 + i), 16'h0, 2'b11, q, ex, lat);
            total++;
            if (q !== 16'hC000 + 16'(i)) begin
                bad++;
                $display("FAIL b2b_data%0d got=%h want=%h", i, q, 16'hC000 + 16'(i));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] q; logic ex; int lat;
        txn(1'b1, 16'd9, 16'h0000, 2'b11, q, ex, lat);
        txn(1'b0, 16'd4000, 16'h0, 2'b11, q, ex, lat);
        req = 1'b1; write = 1'b1; addr = 16'd9; data_in = 16'h5A5A; byte_en = 2'b11;
        while (!ready) @(negedge clk);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("mid reset ready=%b rv=%b flag=%b exc_addr=%0d", ready, resp_valid, exc_flag, exc_addr);
        total++;
        if ({ready, resp_valid, exception, exc_flag} !== 4'b1000 || exc_addr !== 16'h0 ||
            data_out !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset got=%b ea=%h q=%h want=1000 ea=0000 q=0000",
                     {ready, resp_valid, exception, exc_flag}, exc_addr, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1'b0, 16'd9, 16'h0, 2'b11, q, ex, lat);
        total++;
        if (q !== 16'h0000 || ex !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_data got q=%h ex=%b want 0000/0", q, ex);
        end
    endtask

    task automatic test_random;
        logic [15:0] model [32];
        logic        m_flag;
        logic [15:0] m_addr, a, d, q, want_q;
        logic [1:0]  be;
        logic        w, ex, oor;
        int          lat;
        exc_clr = 1'b1;
        @(negedge clk);
        exc_clr = 1'b0;
        m_flag = 1'b0; m_addr = 16'h0;
        for (int i = 0; i < 32; i++) begin
            model[i] = 16'($urandom);
            txn(1'b1, 16'(i), model[i], 2'b11, q, ex, lat);
        end
        for (int t = 0; t < 60; t++) begin
            w   = 1'($urandom);
            d   = 16'($urandom);
            be  = 2'($urandom);
            oor = ($urandom_range(0, 5) == 0);
            a   = oor ? 16'(1024 * $urandom_range(1, 63) + $urandom_range(0, 31))
                      : 16'($urandom_range(0, 31));
            txn(w, a, d, be, q, ex, lat);
            want_q = 16'h0;
            if (!oor && w) model[a] = merge(model[a], d, be);
            if (!oor && !w) want_q = model[a];
            if (oor && !m_flag) begin
                m_flag = 1'b1;
                m_addr = a;
            end
            $display("rand t=%0d w=%b a=%0d d=%h be=%b q=%h ex=%b lat=%0d", t, w, a, d, be, q, ex, lat);
            total++;
            if (q !== want_q || ex !== oor || lat !== WS + 1 || exc_flag !== m_flag ||
                exc_addr !== m_addr) begin
                bad++;
                $display("FAIL rand%0d got q=%h ex=%b lat=%0d fl=%b ea=%0d want q=%h ex=%b lat=%0d fl=%b ea=%0d",
                         t, q, ex, lat, exc_flag, exc_addr, want_q, oor, WS + 1, m_flag, m_addr);
            end
        end
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity;
        logic [15:0] q; logic ex; int lat;
        exc_clr = 1'b1;
        @(negedge clk);
        exc_clr = 1'b0;
        txn(1'b1, 16'd3, 16'h00FF, 2'b11, q, ex, lat);
        dut.mem[3][0] = ~dut.mem[3][0];
        txn(1'b0, 16'd3, 16'h0, 2'b11, q, ex, lat);
        $display("parity read a=3 q=%h ex=%b exc_addr=%0d", q, ex, exc_addr);
        total++;
        if (q !== 16'h00FE || ex !== 1'b1 || exc_flag !== 1'b1 || exc_addr !== 16'd3) begin
            bad++;
            $display("FAIL parity got q=%h ex=%b fl=%b ea=%0d want 00FE/1/1/3", q, ex, exc_flag, exc_addr);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_write_read;
        test_byte_lanes;
        test_out_of_range;
        test_clr_vs_fault;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef DMEM_PARITY_EN
        test_parity;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Clocked, handshaked successor to the combinational data memory.
- Single-port word-addressed RAM with parametrised width, depth and wait states, plus byte-lane write enables.
- Out-of-range accesses raise a registered exception; a sticky exception status records the faulting address.
- Sits between the pipeline MEM stage and storage; the MEM stage stalls while ready is low.

Parameters:
- DATA_ADDR_WIDTH, 16: address width in words.
- DATA_WIDTH, 16: word width; must be a multiple of 8.
- DATA_SIZE, 1024: number of words; legal addresses are 0..DATA_SIZE-1.
- WAIT_STATES, 1: extra cycles between request acceptance and response; 0..15.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 1: request valid; accepted on a clk edge when req && ready.
- write, input, 1: 1 = write, 0 = read; sampled with req.
- addr, input, DATA_ADDR_WIDTH: word address; sampled with req.
- data_in, input, DATA_WIDTH: write data; sampled with req.
- byte_en, input, DATA_WIDTH/8: write lane enables (bit i = bits 8i+7:8i); ignored on reads.
- ready, output, 1: controller can accept a request this cycle.
- resp_valid, output, 1: one-cycle pulse marking completion of the accepted request.
- data_out, output, DATA_WIDTH: read data; valid while resp_valid is high.
- exception, output, 1: one-cycle pulse coincident with resp_valid when the access was out of range.
- exc_flag, output, 1: sticky exception status.
- exc_addr, output, DATA_ADDR_WIDTH: address of the first faulting access since the last clear.
- exc_clr, input, 1: synchronous clear of exc_flag and exc_addr.

Behaviour:
- Reset values: ready=1, resp_valid=0, data_out=0, exception=0, exc_flag=0, exc_addr=0, FSM=IDLE, wait counter=0.
- RAM contents are not reset.
- FSM states:
  - IDLE: ready=1. On req, latch write/addr/data_in/byte_en. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: ready=0. The counter counts WAIT_STATES cycles, then the FSM goes to RESP.
  - RESP: ready=0. For one cycle: resp_valid=1, data_out and exception driven. Then return to IDLE.
- Latency: resp_valid asserts WAIT_STATES+1 cycles after the accepting edge.
- Throughput: one request per WAIT_STATES+2 cycles.
- Write:
  - Performed at the RESP-entry edge.
  - Only lanes with byte_en set are updated.
  - byte_en all zero is a legal no-op that still completes normally.
  - data_out is 0 on a write response.
- Read: data_out = RAM[latched addr] from the RESP cycle.
- Range check: latched addr >= DATA_SIZE is out of range. Then:
  - no RAM write occurs;
  - data_out=0 and exception=1 in the RESP cycle;
  - if exc_flag was 0, exc_flag=1 and exc_addr=addr. A later fault does not overwrite exc_addr while exc_flag=1.
- exc_clr and a new fault in the same cycle: the fault wins (exc_flag=1, exc_addr=new addr).
- req while ready=0 is ignored; the requester must hold req until accepted.
- Inputs are sampled only at acceptance, so changing addr/data_in during WAIT has no effect.
- Reset mid-transaction: FSM returns to IDLE immediately and outputs go to reset values. The in-flight write is dropped if reset precedes RESP entry; RAM is otherwise unchanged.
- Addresses do not wrap; there is no modulo addressing.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - each word stores one extra even-parity bit, computed on the full merged word at write;
  - a read whose stored parity mismatches returns the raw data and raises exception, exc_flag and exc_addr exactly as an out-of-range access does.
  - Words never written are treated as parity-error-free.
- Undefined: no parity storage and no parity check; exception reflects range errors only.

Test Plan:
- Write then read, WAIT_STATES=1: write addr 5, data 0xBEEF, byte_en 2'b11 -> resp_valid 2 cycles after acceptance. Read addr 5 -> data_out=0xBEEF, exception=0.
- Byte lanes: addr 7 holds 0x1234; write 0xABCD with byte_en 2'b01 -> read returns 0x12CD.
- Out-of-range write, addr 1024 -> exception pulse, exc_flag=1, exc_addr=1024, no RAM word changes. Then read addr 2000 -> exc_addr stays 1024. Then exc_clr -> exc_flag=0, exc_addr=0.
- Handshake: req held high continuously with WAIT_STATES=3 -> ready low for exactly 4 cycles per transaction; one resp_valid pulse per request; no request lost or duplicated.
- Reset mid-operation: assert rst_n=0 during WAIT of a write to addr 9 (old value 0x0000) -> outputs at reset values. After release, reading addr 9 returns 0x0000.
- With DMEM_PARITY_EN: write 0x00FF to addr 3, force-flip stored bit 0 -> read returns 0x00FE, exception=1, exc_addr=3.
